// File: rtl/joy_pad_responder.sv
// joy_pad_responder: the pad end of the NES joypad serial link, a 4021-style
// parallel-in/serial-out register. The console drives latch and shift clock;
// this block returns one active-low button bit per shift-clock rising edge.
// All inputs are asynchronous and are synchronized here. The raw buttons are
// debounced before they can be latched into a report.
module joy_pad_responder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PAD_BITS        = 8
) (
  input  logic                pad_clk_in,
  input  logic                rst_n_in,
  input  logic                latch_in,
  input  logic                shift_clk_in,
  input  logic [PAD_BITS-1:0] buttons_n_in,
  output logic                data_n_out,
  output logic [3:0]          shift_count_out,
  output logic [1:0]          state_out,
  output logic                report_done_out
);

  localparam int              CNT_W     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       COUNT_MAX = 4'(PAD_BITS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOADING   = 2'd1,
    ST_SHIFTING  = 2'd2,
    ST_EXHAUSTED = 2'd3
  } state_e;

  // Synchronizer chains; reset values are the idle levels of the console
  // lines so that no phantom edge appears when reset is released.
  logic [SYNC_STAGES-1:0]               latch_sync_q;
  logic [SYNC_STAGES-1:0]               shclk_sync_q;
  logic [SYNC_STAGES-1:0][PAD_BITS-1:0] btn_sync_q;
  logic                                 shclk_prev_q;

  logic                latch_s;
  logic                shift_rise;
  logic [PAD_BITS-1:0] pressed;

  // Debounce state: accepted vector, last sampled vector, stability counter.
  logic [PAD_BITS-1:0] deb_q, deb_d;
  logic [PAD_BITS-1:0] cand_q;
  logic [CNT_W-1:0]    db_cnt_q, db_cnt_d;

  // Report state.
  state_e              state_q, state_d;
  logic [PAD_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]          count_q, count_d;
  logic                done_q, done_d;
  logic                data_n_q;

  // Synchronize every asynchronous input and keep one extra copy of the
  // shift clock for rising-edge detection.
  always_ff @(posedge pad_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      latch_sync_q <= '0;
      shclk_sync_q <= '1;
      btn_sync_q   <= '1;
      shclk_prev_q <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latch_in};
      shclk_sync_q <= {shclk_sync_q[SYNC_STAGES-2:0], shift_clk_in};
      btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], buttons_n_in};
      shclk_prev_q <= shclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign shift_rise = shclk_sync_q[SYNC_STAGES-1] & ~shclk_prev_q;
  assign pressed    = ~btn_sync_q[SYNC_STAGES-1];

  // Accept a new button vector only once it has held still long enough;
  // any change while counting restarts the count from zero.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    if (pressed == deb_q) begin
      db_cnt_d = '0;
    end else if (pressed != cand_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      deb_d    = pressed;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CNT_W'(1);
    end
  end

  // Debounce registers.
  always_ff @(posedge pad_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      deb_q    <= '0;
      cand_q   <= '0;
      db_cnt_q <= '0;
    end else begin
      deb_q    <= deb_d;
      cand_q   <= pressed;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Report FSM and shift register next state. A high latch always wins over
  // a shift edge; a shift in the cycle latch falls acts on the value loaded
  // while latch was still high. Ones fill in from the top, so an exhausted
  // report keeps reading "pressed" like an official pad.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (latch_s) begin
      shreg_d = deb_q;
      count_d = '0;
      state_d = ST_LOADING;
    end else begin
      if (shift_rise) begin
        shreg_d = {1'b1, shreg_q[PAD_BITS-1:1]};
        if (count_q != COUNT_MAX) begin
          count_d = count_q + 4'd1;
        end
      end
      case (state_q)
        ST_LOADING, ST_SHIFTING: begin
          state_d = ST_SHIFTING;
          if (shift_rise && (count_q == COUNT_MAX - 4'd1)) begin
            state_d = ST_EXHAUSTED;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Report registers; the serial output is registered from the next LSB.
  always_ff @(posedge pad_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      data_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      count_q  <= count_d;
      done_q   <= done_d;
      data_n_q <= ~shreg_d[0];
    end
  end

  assign data_n_out      = data_n_q;
  assign shift_count_out = count_q;
  assign state_out       = state_q;
  assign report_done_out = done_q;

endmodule

// File: doc/joy_pad_responder.md
Name: joy_pad_responder

Overview:
- Emulates the controller end of the NES joypad serial protocol, i.e. the 4021-style shift register inside a standard pad.
- The console side drives latch and shift clock. This block answers with one serial, active-low button bit per shift.
- Used to present board push-buttons/switches as a genuine pad on the joystick header, and as a bench partner for the console-side joypad logic.
- All inputs are asynchronous to the block clock and are synchronized internally.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on latch, shift clock and button inputs (minimum 2).
- DEBOUNCE_CYCLES, 50000: cycles the synchronized button vector must stay unchanged before it is accepted (1 ms at 50 MHz; minimum 1).
- PAD_BITS, 8: report length; bit order A, B, Select, Start, Up, Down, Left, Right.

Ports:
- pad_clk_in, input, 1: block clock, rising edge.
- rst_n_in, input, 1: asynchronous, active-low reset.
- latch_in, input, 1: console strobe/latch, active high, asynchronous.
- shift_clk_in, input, 1: console serial clock; idles high, pulses low; asynchronous.
- buttons_n_in, input, PAD_BITS: raw buttons, active low (0 = pressed), asynchronous.
- data_n_out, output, 1: serial data to console, active low (0 = logical 1 = pressed).
- shift_count_out, output, 4: bits shifted since the last latch; saturates at PAD_BITS.
- state_out, output, 2: 0 IDLE, 1 LOADING, 2 SHIFTING, 3 EXHAUSTED.
- report_done_out, output, 1: one-cycle pulse when the PAD_BITS-th shift completes.

Behaviour:

Reset (async assert, sync release):
- shift register = 0, debounced vector = 0, debounce counter = 0.
- All synchronizer flops = idle levels: latch 0, shift clock 1, buttons 1.
- state IDLE, shift_count_out 0, report_done_out 0, data_n_out 1.

Synchronizers and edge detection:
- Every input passes through SYNC_STAGES flops.
- Edges are detected by comparing the last sync stage with one extra registered copy.
- An input edge at cycle t is acted on in cycle t+SYNC_STAGES+1. With SYNC_STAGES=2 the register updates at edge t+3 and data_n_out is visible after it.

Debounce:
- pressed vector = ~synchronized buttons_n_in.
- If it differs from the debounced vector: counter increments; the counter resets to 0 whenever the vector changes again.
- When the counter reaches DEBOUNCE_CYCLES-1 with the vector unchanged, the debounced vector takes the new value and the counter clears.
- Counter width is clog2(DEBOUNCE_CYCLES)+1; it never wraps.

Shift register:
- data_n_out = ~shreg[0] at all times, registered.
- While synchronized latch = 1: shreg loads the debounced vector every cycle, shift_count_out = 0, state LOADING.
- A shift-clock rising edge with latch low: shreg = {1'b1, shreg[PAD_BITS-1:1]} (1 shifted into the MSB) and shift_count_out increments, saturating at PAD_BITS.
- After PAD_BITS shifts, data_n_out reads 0 (logical 1) indefinitely, matching official pads.
- A shift-clock falling edge has no effect.

State machine:
- IDLE -> LOADING: latch high.
- LOADING -> SHIFTING: latch falls.
- SHIFTING -> EXHAUSTED: the shift that makes the count reach PAD_BITS. report_done_out pulses in that same cycle.
- EXHAUSTED stays put on further shifts (no further pulses); -> LOADING on latch high.
- Latch rising from any state -> LOADING.
- No timeout back to IDLE. IDLE is reached only by reset.

Boundary cases:
- Shift edge while latch is high: the load wins, no shift, count stays 0.
- Latch falls and a shift edge arrives in the same cycle: the load is already complete because latch was high the previous cycle; the shift applies to the loaded value, count = 1.
- Button change during SHIFTING: no effect on the current report; the new value is used at the next latch.
- Reset mid-shift: everything returns to reset values immediately.

Test Plan:
1. Reset → data_n_out=1, shift_count_out=0, state_out=0, report_done_out=0. Check asynchronously, before any clock edge.
2. DEBOUNCE_CYCLES=4; buttons_n_in=8'b1111_0110 (A and Start pressed) held 10 cycles; pulse latch; 8 shift pulses → data_n_out sequence 0,1,1,0,1,1,1,1. report_done_out pulses once on shift 8; state_out=3.
3. Continue with 3 more shifts after case 2 → data_n_out stays 0, count stays 8, no further report_done_out pulse. Then pulse latch → count=0 and data_n_out=0 (A still pressed).
4. Button glitch of 2 cycles with DEBOUNCE_CYCLES=4, then latch and shift → report reflects the old vector (all data_n_out bits 1 for unpressed).
5. Hold latch high and toggle shift_clk_in 3 times → no shifts, count=0, data_n_out tracks bit A. Measure latency: a latch rise at cycle t updates data_n_out after edge t+3.
6. Assert rst_n_in after 4 shifts → immediate reset values. After release and a new latch, the report restarts from bit A.
